// File: rtl/range_pkg.sv
// ---------------------------------------------------------------------------
// range_pkg
// Shared definitions for the range-family stimulus blocks.
//   rs_state_t : sequencer state encoding (RS_IDLE, RS_RUN, RS_DONE)
//   RANGE_W    : default base-value width of the range block
//   RANGE_W2   : default wide-operand width of the range block (RANGE_W+1)
// ---------------------------------------------------------------------------
package range_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_RUN  = 2'd1,
    RS_DONE = 2'd2
  } rs_state_t;

  localparam int RANGE_W  = 4;
  localparam int RANGE_W2 = RANGE_W + 1;

endpackage : range_pkg

// File: rtl/range_step.sv
// ---------------------------------------------------------------------------
// range_step
// Combinational width arithmetic for one range value.
//   cur  (in,  W)      : current base value
//   hi   (in,  W)      : inclusive upper bound
//   nxt  (out, W2)     : cur+STEP, W2-wide so it never overflows
//   last (out, 1)      : nxt lies beyond hi, i.e. cur is the final value
//   in2  (out, 2*W2)   : cur*cur, zero-extended
//   in3  (out, W2)     : cur+1, zero-extended
// ---------------------------------------------------------------------------
module range_step
  import range_pkg::*;
#(
  parameter int W    = RANGE_W,
  parameter int W2   = RANGE_W2,
  parameter int STEP = 1
) (
  input  logic [W-1:0]    cur,
  input  logic [W-1:0]    hi,
  output logic [W2-1:0]   nxt,
  output logic            last,
  output logic [2*W2-1:0] in2,
  output logic [W2-1:0]   in3
);

  logic [W2-1:0]   cur_ext_s;
  logic [W2-1:0]   hi_ext_s;
  logic [2*W2-1:0] cur_wide_s;

  assign cur_ext_s  = {{(W2-W){1'b0}}, cur};
  assign hi_ext_s   = {{(W2-W){1'b0}}, hi};
  assign cur_wide_s = {{(2*W2-W){1'b0}}, cur};

  assign nxt  = cur_ext_s + W2'(STEP);
  assign last = (nxt > hi_ext_s);
  assign in2  = cur_wide_s * cur_wide_s;
  assign in3  = cur_ext_s + {{(W2-1){1'b0}}, 1'b1};

endmodule : range_step

// File: rtl/range_stim.sv
// ---------------------------------------------------------------------------
// range_stim
// Walks a value from lo to hi in steps of STEP and presents each value as one
// valid/ready beat carrying the three operands of the range block.
// Optional build macro: RANGE_STIM_WRAP_EN (continuous wrap-around mode,
// start during a run requests a stop at the next transfer).
//   clk       (in)        : clock, rising edge
//   rst       (in)        : asynchronous active-low reset
//   start     (in)        : single-cycle run request
//   lo, hi    (in,  W)    : range bounds, latched on an accepted start
//   out_valid (out)       : beat presented
//   out_ready (in)        : downstream accepts the beat
//   in1       (out, W)    : current value
//   in2       (out, 2*W2) : current value squared
//   in3       (out, W2)   : current value plus one
//   busy      (out)       : sequencer not idle
//   done      (out)       : one-cycle end-of-run (or wrap) pulse
//   count     (out, W2)   : beats transferred in the current run
// ---------------------------------------------------------------------------
module range_stim
  import range_pkg::*;
#(
  parameter int W    = RANGE_W,
  parameter int W2   = RANGE_W2,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    lo,
  input  logic [W-1:0]    hi,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    in1,
  output logic [2*W2-1:0] in2,
  output logic [W2-1:0]   in3,
  output logic            busy,
  output logic            done,
  output logic [W2-1:0]   count
);

  rs_state_t       state_r,     state_s;
  logic [W-1:0]    cur_r,       cur_s;
  logic [W-1:0]    lo_r,        lo_s;
  logic [W-1:0]    hi_r,        hi_s;
  logic [W2-1:0]   count_r,     count_s;
  logic            out_valid_r, out_valid_s;
  logic [W-1:0]    in1_r,       in1_s;
  logic [2*W2-1:0] in2_r,       in2_s;
  logic [W2-1:0]   in3_r,       in3_s;
  logic            busy_r,      busy_s;
  logic            done_r,      done_s;
  logic            stop_r,      stop_s;

  logic            xfer_s;
  logic            load_en_s;
  logic [W-1:0]    load_val_s;
  logic [W2-1:0]   nxt_s;
  logic            last_s;
  logic [2*W2-1:0] cur_in2_s;
  logic [W2-1:0]   cur_in3_s;
  logic [W2-1:0]   ld_nxt_s;
  logic            ld_last_s;
  logic [2*W2-1:0] ld_in2_s;
  logic [W2-1:0]   ld_in3_s;
  logic            unused_s;

  assign xfer_s = out_valid_r & out_ready;

  // Step arithmetic on the value currently presented.
  range_step #(.W(W), .W2(W2), .STEP(STEP)) u_step_cur (
    .cur  (cur_r),
    .hi   (hi_r),
    .nxt  (nxt_s),
    .last (last_s),
    .in2  (cur_in2_s),
    .in3  (cur_in3_s)
  );

  // Operand derivation for the value about to be loaded into the beat.
  range_step #(.W(W), .W2(W2), .STEP(STEP)) u_step_load (
    .cur  (load_val_s),
    .hi   (hi_r),
    .nxt  (ld_nxt_s),
    .last (ld_last_s),
    .in2  (ld_in2_s),
    .in3  (ld_in3_s)
  );

  assign unused_s = ^{cur_in2_s, cur_in3_s, ld_nxt_s, ld_last_s, nxt_s[W2-1:W]};

  // Next-state and next-output logic. In RUN, out_valid_r low marks the
  // single setup cycle in which the first beat is loaded from cur_r.
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    lo_s        = lo_r;
    hi_s        = hi_r;
    count_s     = count_r;
    out_valid_s = out_valid_r;
    stop_s      = stop_r;
    done_s      = 1'b0;
    load_en_s   = 1'b0;
    load_val_s  = cur_r;

    case (state_r)
      RS_IDLE: begin
        if (start) begin
          lo_s    = lo;
          hi_s    = hi;
          cur_s   = lo;
          count_s = {W2{1'b0}};
          stop_s  = 1'b0;
          if (lo > hi) begin
            state_s = RS_DONE;
          end else begin
            state_s = RS_RUN;
          end
        end else begin
          state_s = RS_IDLE;
        end
      end

      RS_RUN: begin
        if (!out_valid_r) begin
          out_valid_s = 1'b1;
          load_en_s   = 1'b1;
          load_val_s  = cur_r;
        end else if (xfer_s) begin
          count_s = count_r + {{(W2-1){1'b0}}, 1'b1};
`ifdef RANGE_STIM_WRAP_EN
          if (stop_r || start) begin
            state_s     = RS_DONE;
            out_valid_s = 1'b0;
            done_s      = 1'b1;
          end else if (last_s) begin
            cur_s      = lo_r;
            load_en_s  = 1'b1;
            load_val_s = lo_r;
            done_s     = 1'b1;
          end else begin
            cur_s      = nxt_s[W-1:0];
            load_en_s  = 1'b1;
            load_val_s = nxt_s[W-1:0];
          end
`else
          if (last_s) begin
            state_s     = RS_DONE;
            out_valid_s = 1'b0;
            done_s      = 1'b1;
          end else begin
            cur_s      = nxt_s[W-1:0];
            load_en_s  = 1'b1;
            load_val_s = nxt_s[W-1:0];
          end
`endif
        end else begin
`ifdef RANGE_STIM_WRAP_EN
          stop_s = stop_r | start;
`else
          stop_s = 1'b0;
`endif
        end
      end

      RS_DONE: begin
        // Entered from RUN with done already raised; the empty-range path
        // arrives with done low and raises it here first.
        if (done_r) begin
          state_s = RS_IDLE;
        end else begin
          done_s = 1'b1;
        end
      end

      default: begin
        state_s     = RS_IDLE;
        out_valid_s = 1'b0;
      end
    endcase

    if (load_en_s) begin
      in1_s = load_val_s;
      in2_s = ld_in2_s;
      in3_s = ld_in3_s;
    end else begin
      in1_s = in1_r;
      in2_s = in2_r;
      in3_s = in3_r;
    end

    busy_s = (state_s != RS_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RS_IDLE;
      cur_r       <= {W{1'b0}};
      lo_r        <= {W{1'b0}};
      hi_r        <= {W{1'b0}};
      count_r     <= {W2{1'b0}};
      out_valid_r <= 1'b0;
      in1_r       <= {W{1'b0}};
      in2_r       <= {(2*W2){1'b0}};
      in3_r       <= {W2{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      stop_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      lo_r        <= lo_s;
      hi_r        <= hi_s;
      count_r     <= count_s;
      out_valid_r <= out_valid_s;
      in1_r       <= in1_s;
      in2_r       <= in2_s;
      in3_r       <= in3_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      stop_r      <= stop_s;
    end
  end

  assign out_valid = out_valid_r;
  assign in1       = in1_r;
  assign in2       = in2_r;
  assign in3       = in3_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign count     = count_r;

endmodule : range_stim

// File: tb/tb_range_stim.sv
// ---------------------------------------------------------------------------
// tb_range_stim
// Directed bench for range_stim: three instances (STEP=1, 4, 15) share clock,
// reset, bounds and ready; each has its own start.
// ---------------------------------------------------------------------------
module tb_range_stim;

  logic       clk;
  logic       rst;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       ready;
  logic       start1, start4, start15;

  logic       v1, v4, v15;
  logic [3:0] a1, a4, a15;
  logic [9:0] b1, b4, b15;
  logic [4:0] c1, c4, c15;
  logic       busy1, busy4, busy15;
  logic       done1, done4, done15;
  logic [4:0] cnt1, cnt4, cnt15;

  int errors = 0;
  int checks = 0;

  range_stim #(.W(4), .W2(5), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .lo(lo), .hi(hi),
    .out_valid(v1), .out_ready(ready), .in1(a1), .in2(b1), .in3(c1),
    .busy(busy1), .done(done1), .count(cnt1)
  );

  range_stim #(.W(4), .W2(5), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .lo(lo), .hi(hi),
    .out_valid(v4), .out_ready(ready), .in1(a4), .in2(b4), .in3(c4),
    .busy(busy4), .done(done4), .count(cnt4)
  );

  range_stim #(.W(4), .W2(5), .STEP(15)) dut15 (
    .clk(clk), .rst(rst), .start(start15), .lo(lo), .hi(hi),
    .out_valid(v15), .out_ready(ready), .in1(a15), .in2(b15), .in3(c15),
    .busy(busy15), .done(done15), .count(cnt15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int          exp_v;
    int          beats;
    bit          saw_done;
    bit          xfer;
    logic [15:0] pat;
    int          basic_in1 [4];
    int          basic_in2 [4];
    int          basic_in3 [4];
    int          stride_in1 [3];

    basic_in1  = '{3, 4, 5, 6};
    basic_in2  = '{9, 16, 25, 36};
    basic_in3  = '{4, 5, 6, 7};
    stride_in1 = '{1, 5, 9};

    rst = 1'b0; lo = 4'd0; hi = 4'd0; ready = 1'b1;
    start1 = 1'b0; start4 = 1'b0; start15 = 1'b0;
    #12;
    check("rst_valid", v1, 0);
    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_count", cnt1, 0);
    check("rst_ops",   {a1, b1, c1}, 0);
    rst = 1'b1;
    step();

    // Basic run 3..6, STEP=1
    lo = 4'd3; hi = 4'd6; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("basic_setup_busy",  busy1, 1);
    check("basic_setup_valid", v1, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("basic_valid", v1, 1);
      check("basic_in1", a1, basic_in1[i]);
      check("basic_in2", b1, basic_in2[i]);
      check("basic_in3", c1, basic_in3[i]);
      check("basic_nodone", done1, 0);
      step();
    end
    check("basic_done",  done1, 1);
    check("basic_busy_d", busy1, 1);
    check("basic_valid_end", v1, 0);
    check("basic_count", cnt1, 4);
    step();
    check("basic_done_pulse", done1, 0);
    check("basic_idle", busy1, 0);
    check("basic_count_hold", cnt1, 4);

    // Stride overshoot 1..10, STEP=4
    lo = 4'd1; hi = 4'd10; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("stride_valid", v4, 1);
      check("stride_in1", a4, stride_in1[i]);
      step();
    end
    check("stride_done",  done4, 1);
    check("stride_valid_end", v4, 0);
    check("stride_count", cnt4, 3);

    // Extremes lo=hi=15, STEP=15
    lo = 4'd15; hi = 4'd15; start15 = 1'b1;
    step();
    start15 = 1'b0;
    step();
    check("ext_valid", v15, 1);
    check("ext_in1", a15, 15);
    check("ext_in2", b15, 225);
    check("ext_in3", c15, 16);
    step();
    check("ext_done",  done15, 1);
    check("ext_count", cnt15, 1);
    check("ext_valid_end", v15, 0);

    // Empty range 7..2
    step();
    lo = 4'd7; hi = 4'd2; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("empty_valid0", v1, 0);
    check("empty_done0",  done1, 0);
    check("empty_busy0",  busy1, 1);
    step();
    check("empty_valid1", v1, 0);
    check("empty_done1",  done1, 1);
    check("empty_count",  cnt1, 0);
    step();
    check("empty_done2", done1, 0);
    check("empty_idle",  busy1, 0);

    // Backpressure on 3..6
    pat = 16'b1011_0010_1101_0110;
    lo = 4'd3; hi = 4'd6; start1 = 1'b1;
    step();
    start1 = 1'b0;
    exp_v = 3; beats = 0; saw_done = 1'b0;
    for (int cyc = 0; cyc < 60 && !saw_done; cyc++) begin
      if (done1) begin
        saw_done = 1'b1;
      end else begin
        if (v1) begin
          check("bp_in1", a1, exp_v);
          check("bp_in2", b1, exp_v * exp_v);
          check("bp_in3", c1, exp_v + 1);
        end
        ready = pat[cyc % 16];
`ifndef RANGE_STIM_WRAP_EN
        start1 = (cyc == 5);
`endif
        xfer = v1 & ready;
        step();
        start1 = 1'b0;
        if (xfer) begin
          beats++;
          exp_v++;
        end
      end
    end
    ready = 1'b1;
    check("bp_done_seen", saw_done, 1);
    check("bp_beats", beats, 4);
    check("bp_count", cnt1, 4);
    step();
    check("bp_idle", busy1, 0);

    // Reset mid-run
    lo = 4'd3; hi = 4'd6; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    step();
    check("mid_in1_before", a1, 5);
    #2;
    rst = 1'b0;
    #1;
    check("mid_valid", v1, 0);
    check("mid_busy",  busy1, 0);
    check("mid_count", cnt1, 0);
    check("mid_ops",   {a1, b1, c1}, 0);
    rst = 1'b1;
    step();
    lo = 4'd0; hi = 4'd2; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("post_valid", v1, 1);
      check("post_in1", a1, i);
      check("post_in2", b1, i * i);
      check("post_in3", c1, i + 1);
      step();
    end
    check("post_done",  done1, 1);
    check("post_count", cnt1, 3);
    step();

`ifdef RANGE_STIM_WRAP_EN
    // Wrap 0..1 with a stop request
    step();
    lo = 4'd0; hi = 4'd1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("wrap_b0", a1, 0);
    check("wrap_d0", done1, 0);
    step();
    check("wrap_b1", a1, 1);
    check("wrap_d1", done1, 0);
    step();
    check("wrap_b2", a1, 0);
    check("wrap_d2", done1, 1);
    check("wrap_v2", v1, 1);
    step();
    check("wrap_b3", a1, 1);
    check("wrap_d3", done1, 0);
    step();
    check("wrap_b4", a1, 0);
    check("wrap_d4", done1, 1);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("wrap_stop_done",  done1, 1);
    check("wrap_stop_valid", v1, 0);
    check("wrap_stop_count", cnt1, 5);
    step();
    check("wrap_stop_idle", busy1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_range_stim
